// File: rtl/pcpi_vec_coproc.sv
// Minimal vector coprocessor on the picorv32 PCPI port: vsetvli, strided load/store and
// an elementwise multiply-accumulate (vdot.vv), with a private word memory port.
module pcpi_vec_coproc #(
  parameter int unsigned VLMAX = 8,
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_cpurs1,
  input  logic [31:0] pcpi_cpurs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IW = $clog2(VLMAX + 1);
  localparam int unsigned AW = $clog2(NREGS * VLMAX);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  typedef enum logic [1:0] {OpSetvl, OpLoad, OpStore, OpDot} op_e;

  state_e        state_q;
  op_e           op_q;
  logic          skip_q;
  logic [IW-1:0] vl_q;
  logic [IW-1:0] idx_q;
  logic [10:0]   vtype_q;
  logic [10:0]   vtypei_q;
  logic [4:0]    vd_q;
  logic [4:0]    vs1_q;
  logic [4:0]    vs2_q;
  logic [31:0]   rs1_q;
  logic [31:0]   rs2_q;

  logic [31:0] vregs [NREGS*VLMAX];

  function automatic logic [AW-1:0] eidx(input logic [4:0] r, input logic [IW-1:0] e);
    return AW'(32'(r) * VLMAX + 32'(e));
  endfunction

  logic dec_setvl, dec_load, dec_store, dec_dot, dec_any;
  assign dec_setvl = (pcpi_insn[6:0] == 7'b1010111) && (pcpi_insn[14:12] == 3'b111) &&
                     !pcpi_insn[31];
  assign dec_load  = (pcpi_insn[6:0] == 7'b0000111) && (pcpi_insn[14:12] == 3'b111) &&
                     (pcpi_insn[28:26] == 3'b010);
  assign dec_store = (pcpi_insn[6:0] == 7'b0100111) && (pcpi_insn[14:12] == 3'b111) &&
                     (pcpi_insn[28:26] == 3'b010);
  assign dec_dot   = (pcpi_insn[6:0] == 7'b1010111) && (pcpi_insn[14:12] == 3'b000) &&
                     (pcpi_insn[31:26] == 6'b111001);
  assign dec_any   = dec_setvl | dec_load | dec_store | dec_dot;

  logic [IW-1:0] idx_next;
  logic [IW-1:0] vl_new;
  logic [31:0]   elem_cur;
  logic [31:0]   elem_next;
  logic [31:0]   dot_sum;
  assign idx_next  = idx_q + IW'(1);
  assign vl_new    = (rs1_q > 32'(VLMAX)) ? IW'(VLMAX) : rs1_q[IW-1:0];
  assign elem_cur  = vregs[eidx(vd_q, idx_q)];
  assign elem_next = vregs[eidx(vd_q, idx_next)];
  // Sources are read combinationally, so vd aliasing vs1/vs2 sees pre-write values.
  assign dot_sum   = elem_cur + vregs[eidx(vs2_q, idx_q)] * vregs[eidx(vs1_q, idx_q)];

  logic unused_bits;
  assign unused_bits = ^{vtype_q, pcpi_insn[25]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpSetvl;
      skip_q     <= 1'b0;
      vl_q       <= '0;
      idx_q      <= '0;
      vtype_q    <= '0;
      vtypei_q   <= '0;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          skip_q <= 1'b0;
          // The CPU may still hold pcpi_valid on the cycle right after completion.
          if (!skip_q && pcpi_valid && dec_any) begin
            state_q   <= StExec;
            pcpi_wait <= 1'b1;
            op_q      <= dec_setvl ? OpSetvl : dec_load ? OpLoad : dec_store ? OpStore : OpDot;
            vtypei_q  <= pcpi_insn[30:20];
            vd_q      <= pcpi_insn[11:7];
            vs1_q     <= pcpi_insn[19:15];
            vs2_q     <= pcpi_insn[24:20];
            rs1_q     <= pcpi_cpurs1;
            rs2_q     <= pcpi_cpurs2;
            idx_q     <= '0;
          end
        end
        StExec: begin
          unique case (op_q)
            OpSetvl: begin
              vl_q       <= vl_new;
              vtype_q    <= vtypei_q;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= 32'(vl_new);
              state_q    <= StDone;
              pcpi_ready <= 1'b1;
              pcpi_wait  <= 1'b0;
            end
            OpDot: begin
              if (idx_q >= vl_q) begin
                state_q    <= StDone;
                pcpi_ready <= 1'b1;
                pcpi_wait  <= 1'b0;
              end else begin
                vregs[eidx(vd_q, idx_q)] <= dot_sum;
                idx_q <= idx_next;
              end
            end
            OpLoad, OpStore: begin
              if (!mem_valid) begin
                if (idx_q >= vl_q) begin
                  state_q    <= StDone;
                  pcpi_ready <= 1'b1;
                  pcpi_wait  <= 1'b0;
                end else begin
                  mem_valid <= 1'b1;
                  mem_addr  <= rs1_q;
                  mem_wstrb <= (op_q == OpStore) ? 4'hf : 4'h0;
                  mem_wdata <= (op_q == OpStore) ? elem_cur : 32'h0;
                end
              end else if (mem_ready) begin
                if (op_q == OpLoad) begin
                  vregs[eidx(vd_q, idx_q)] <= mem_rdata;
                end
                idx_q <= idx_next;
                if (idx_next < vl_q) begin
                  mem_addr  <= mem_addr + rs2_q;
                  mem_wdata <= (op_q == OpStore) ? elem_next : 32'h0;
                end else begin
                  mem_valid  <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
                  mem_wstrb  <= '0;
                  state_q    <= StDone;
                  pcpi_ready <= 1'b1;
                  pcpi_wait  <= 1'b0;
                end
              end
            end
            default: state_q <= StIdle;
          endcase
        end
        StDone: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_rd    <= '0;
          skip_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_vec_coproc.sv
// Directed bench for pcpi_vec_coproc with a behavioural word memory of adjustable latency.
module tb_pcpi_vec_coproc;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_cpurs1, pcpi_cpurs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  pcpi_vec_coproc #(.VLMAX(8), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_cpurs1(pcpi_cpurs1), .pcpi_cpurs2(pcpi_cpurs2), .pcpi_wr(pcpi_wr),
    .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] mem [1024];
  int          delay = 0;
  int          cnt = 0;
  logic        unstable = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_strb;
  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  logic [3:0]  acc_strb [$];

  // Memory responder: acknowledges after `delay` extra cycles, logs each access.
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else if (mem_valid) begin
      if (cnt == 0) begin
        hold_addr = mem_addr; hold_wdata = mem_wdata; hold_strb = mem_wstrb;
      end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata ||
                   mem_wstrb !== hold_strb) begin
        unstable = 1'b1;
      end
      if (cnt == delay) begin
        mem_ready = 1'b1;
        acc_addr.push_back(mem_addr);
        acc_strb.push_back(mem_wstrb);
        if (mem_wstrb == 4'hf) begin
          mem[mem_addr[11:2]] = mem_wdata;
          acc_data.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr[11:2]];
          acc_data.push_back(mem_rdata);
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  function automatic logic [31:0] vlse(input int vd);
    return 32'h0A007007 | (32'(vd) << 7);
  endfunction
  function automatic logic [31:0] vsse(input int vs3);
    return 32'h0A007027 | (32'(vs3) << 7);
  endfunction
  function automatic logic [31:0] vdot(input int vd, input int vs2, input int vs1);
    return 32'hE6000057 | (32'(vs2) << 20) | (32'(vs1) << 15) | (32'(vd) << 7);
  endfunction
  function automatic logic [31:0] word_pat(input int i);
    return 32'h201 + 32'(i) * 32'h404;
  endfunction

  task automatic clear_log();
    acc_addr.delete(); acc_data.delete(); acc_strb.delete();
  endtask

  // Offers one instruction; n = posedges from the sampling edge until ready is seen.
  task automatic run_insn(input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, output int n, output logic wr,
                          output logic [31:0] rd, output logic wait1);
    logic got;
    @(posedge clk);
    @(negedge clk);
    pcpi_insn = insn; pcpi_cpurs1 = rs1; pcpi_cpurs2 = rs2; pcpi_valid = 1'b1;
    n = 0; got = 1'b0; wr = 1'b0; rd = '0; wait1 = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) wait1 = pcpi_wait;
      if (pcpi_ready) begin
        got = 1'b1; wr = pcpi_wr; rd = pcpi_rd;
      end
    end
    pcpi_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL timeout insn=%08h: no pcpi_ready within %0d cycles", insn, n);
    end else begin
      @(posedge clk); #1;
      if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) begin
        bad++;
        $display("FAIL ready_pulse insn=%08h: ready=%b wait=%b, required 0 0", insn,
                 pcpi_ready, pcpi_wait);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if (pcpi_wr !== 1'b0 || pcpi_rd !== 32'h0 || pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 ||
        mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      bad++;
      $display("FAIL %s: wr=%b rd=%h wait=%b ready=%b mv=%b ma=%h md=%h ms=%h, required all 0",
               name, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, mem_valid, mem_addr, mem_wdata,
               mem_wstrb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vl_zero(input string name);
    logic [31:0] insns [3];
    int n; logic wr, w1; logic [31:0] rd;
    insns[0] = vlse(5); insns[1] = vsse(5); insns[2] = vdot(5, 6, 7);
    for (int k = 0; k < 3; k++) begin
      clear_log();
      run_insn(insns[k], 32'd400, 32'd4, n, wr, rd, w1);
      total++;
      if (n !== 2 || acc_addr.size() != 0 || wr !== 1'b0 || rd !== 32'h0) begin
        bad++;
        $display("FAIL %s_%0d: latency=%0d accesses=%0d wr=%b rd=%h, required 2 0 0 0",
                 name, k, n, acc_addr.size(), wr, rd);
      end
    end
  endtask

  task automatic test_setvl();
    logic [31:0] avl [3];
    logic [31:0] exp [3];
    int n; logic wr, w1; logic [31:0] rd;
    avl[0] = 32'd8; avl[1] = 32'd20; avl[2] = 32'd3;
    exp[0] = 32'd8; exp[1] = 32'd8;  exp[2] = 32'd3;
    for (int k = 0; k < 3; k++) begin
      run_insn(32'h00817257, avl[k], 32'd0, n, wr, rd, w1);
      total++;
      if (rd !== exp[k] || wr !== 1'b1 || n !== 2 || w1 !== 1'b1) begin
        bad++;
        $display("FAIL setvl_avl%0d: rd=%0d wr=%b latency=%0d wait=%b, required %0d 1 2 1",
                 avl[k], rd, wr, n, w1, exp[k]);
      end
    end
  endtask

  // Checks the access log against base/stride, strobe and expected data words.
  task automatic check_log(input string name, input logic [31:0] base, input logic [31:0] stride,
                           input logic [3:0] strb, input logic [31:0] data [8]);
    total++;
    if (acc_addr.size() != 8) begin
      bad++;
      $display("FAIL %s_count: accesses=%0d, required 8", name, acc_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (acc_addr[i] !== base + 32'(i) * stride || acc_strb[i] !== strb ||
            acc_data[i] !== data[i]) begin
          bad++;
          $display("FAIL %s_elem%0d: addr=%0d strb=%h data=%h, required %0d %h %h", name, i,
                   acc_addr[i], acc_strb[i], acc_data[i], base + 32'(i) * stride, strb, data[i]);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] exp [8];
    int n; logic wr, w1; logic [31:0] rd;
    run_insn(32'h00817257, 32'd8, 32'd0, n, wr, rd, w1);
    for (int i = 0; i < 8; i++) begin
      mem[100 + i] = word_pat(i);
      mem[200 + i] = 32'h93;
      exp[i] = word_pat(i);
    end
    clear_log();
    run_insn(vlse(1), 32'd400, 32'd4, n, wr, rd, w1);
    total++;
    if (wr !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL load_wr: wr=%b rd=%h, required 0 0", wr, rd);
    end
    check_log("load_v1", 32'd400, 32'd4, 4'h0, exp);
    clear_log();
    run_insn(vsse(1), 32'd2000, 32'd4, n, wr, rd, w1);
    check_log("readback_v1", 32'd2000, 32'd4, 4'hf, exp);
    run_insn(vlse(2), 32'd400, 32'd4, n, wr, rd, w1);
    run_insn(vlse(8), 32'd800, 32'd4, n, wr, rd, w1);
  endtask

  task automatic test_dot_store();
    logic [31:0] exp [8];
    int n; logic wr, w1; logic [31:0] rd;
    for (int i = 0; i < 8; i++) exp[i] = 32'h93 + word_pat(i) * word_pat(i);
    run_insn(vdot(8, 2, 1), 32'd0, 32'd0, n, wr, rd, w1);
    total++;
    if (wr !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL dot_wr: wr=%b rd=%h, required 0 0", wr, rd);
    end
    clear_log();
    run_insn(vsse(8), 32'd800, 32'd4, n, wr, rd, w1);
    total++;
    if (acc_data.size() < 1 || acc_data[0] !== 32'h00040494) begin
      bad++;
      $display("FAIL dot_elem0: got %h, required 00040494",
               (acc_data.size() > 0) ? acc_data[0] : 32'hx);
    end
    check_log("store_s4", 32'd800, 32'd4, 4'hf, exp);
    clear_log();
    run_insn(vsse(8), 32'd800, 32'd8, n, wr, rd, w1);
    check_log("store_s8", 32'd800, 32'd8, 4'hf, exp);
  endtask

  task automatic test_delay();
    logic [31:0] exp [8];
    int n; logic wr, w1; logic [31:0] rd;
    for (int i = 0; i < 8; i++) exp[i] = word_pat(i);
    delay = 3;
    unstable = 1'b0;
    clear_log();
    run_insn(vlse(3), 32'd400, 32'd4, n, wr, rd, w1);
    check_log("slow_load", 32'd400, 32'd4, 4'h0, exp);
    clear_log();
    run_insn(vsse(3), 32'd1600, 32'd4, n, wr, rd, w1);
    check_log("slow_store", 32'd1600, 32'd4, 4'hf, exp);
    total++;
    if (unstable !== 1'b0) begin
      bad++;
      $display("FAIL slow_stable: request changed before mem_ready (flag=%b), required 0",
               unstable);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[400 + i] !== exp[i]) begin
        bad++;
        $display("FAIL slow_mem%0d: got %h, required %h", i, mem[400 + i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; logic wr, w1; logic [31:0] rd;
    delay = 3;
    @(posedge clk);
    @(negedge clk);
    pcpi_insn = vlse(4); pcpi_cpurs1 = 32'd400; pcpi_cpurs2 = 32'd4; pcpi_valid = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    delay = 0;
    test_vl_zero("after_reset_vl0");
    run_insn(32'h00817257, 32'd5, 32'd0, n, wr, rd, w1);
    total++;
    if (rd !== 32'd5 || wr !== 1'b1 || n !== 2) begin
      bad++;
      $display("FAIL setvl_after_reset: rd=%0d wr=%b latency=%0d, required 5 1 2", rd, wr, n);
    end
  endtask

  task automatic test_unknown();
    logic seen;
    seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pcpi_insn = 32'h00000093; pcpi_cpurs1 = 32'd1; pcpi_cpurs2 = 32'd1; pcpi_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (pcpi_wait || pcpi_ready || pcpi_wr || mem_valid) seen = 1'b1;
    end
    pcpi_valid = 1'b0;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL unknown_insn: claimed=%b, required 0", seen);
    end
  endtask

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_cpurs1 = '0; pcpi_cpurs2 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_vl_zero("reset_vl0");
    test_setvl();
    test_load();
    test_dot_store();
    test_delay();
    test_reset_mid();
    test_unknown();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcpi_vec_coproc.md
Name: pcpi_vec_coproc

Overview:
- Minimal RISC-V vector coprocessor attached to the picorv32 PCPI port.
- Supports four instructions: vsetvli, strided load vlse.v, strided store vsse.v, and vdot.vv.
- Holds 32 vector registers with a fixed 32-bit element width.
- Owns a private 32-bit word memory port, separate from the CPU bus.

Parameters:
- VLMAX, 8: elements per vector register; hardware upper bound on vl.
- NREGS, 32: number of vector registers.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- pcpi_valid  in  1  CPU offers an instruction; held until pcpi_ready.
- pcpi_insn  in  32  instruction word.
- pcpi_cpurs1  in  32  CPU rs1 value: AVL for vsetvli, base address for load/store.
- pcpi_cpurs2  in  32  CPU rs2 value: byte stride for load/store.
- pcpi_wr  out  1  write pcpi_rd into the CPU rd (vsetvli only).
- pcpi_rd  out  32  result returned to the CPU.
- pcpi_wait  out  1  instruction accepted and in progress.
- pcpi_ready  out  1  one-cycle completion pulse.
- mem_valid  out  1  memory request.
- mem_ready  in  1  one-cycle memory acknowledge.
- mem_addr  out  32  byte address (word aligned).
- mem_wdata  out  32  store data.
- mem_wstrb  out  4  byte enables: 0000 = read, 1111 = write.
- mem_rdata  in  32  read data, valid with mem_ready.

Behaviour:
- Reset:
  - Outputs pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, mem_valid, mem_addr, mem_wdata and mem_wstrb are 0.
  - vl=0, vtype=0, FSM=IDLE. Vector register contents are not reset.
  - Reset mid-operation abandons the instruction: all outputs are 0 on the cycle after reset is sampled, and no partial register write is performed.
- Decode (bit fields of pcpi_insn):
  - vsetvli: opcode[6:0]=1010111, funct3=111, bit31=0. vtypei=insn[30:20].
  - vlse.v: opcode 0000111, width=111, mop[28:26]=010, vd=insn[11:7].
  - vsse.v: opcode 0100111, width=111, mop=010, vs3=insn[11:7].
  - vdot.vv: opcode 1010111, funct3=000, funct6[31:26]=111001, vs2=[24:20], vs1=[19:15], vd=[11:7].
  - vm (bit25) is ignored: all operations are unmasked.
  - Any other instruction is not claimed: wait, ready and wr stay 0, so the CPU raises its illegal-instruction trap.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: when pcpi_valid is high and the instruction decodes, latch insn, rs1 and rs2, set element index i=0, and assert pcpi_wait from the next cycle. pcpi_wait stays high until the DONE cycle.
  - DONE: pcpi_ready=1 for exactly one cycle, with pcpi_wait dropped in the same cycle. pcpi_valid is ignored in the cycle following DONE.
- vsetvli:
  - vl = min(rs1, VLMAX); vtype = vtypei.
  - Completes with pcpi_wr=1 and pcpi_rd=vl in the DONE cycle; DONE is 2 cycles after pcpi_valid is sampled.
  - SEW/LMUL fields are recorded only; elements are always 32 bits.
- vlse.v / vsse.v:
  - For each element i < vl: address = rs1 + i*rs2 (32-bit wrap-around).
  - One request at a time. mem_valid stays high until mem_ready is sampled.
  - For the next element, mem_valid may be held high on the following cycle, with the new address.
  - Loads write mem_rdata into vd[i] on the mem_ready cycle.
  - Stores drive mem_wdata=vs3[i] and mem_wstrb=1111 for the full duration of the request.
  - After the last element completes: DONE.
- vdot.vv:
  - For each element i < vl, one element per cycle: vd[i] = vd[i] + vs2[i]*vs1[i], keeping the low 32 bits (unsigned product, modulo 2^32).
  - Elements at index >= vl are unchanged.
  - vd may alias vs1 or vs2: each element reads its sources before writing that element.
- vl=0: load, store and dot complete with no memory access and no register change; DONE 2 cycles after pcpi_valid.
- pcpi_wr=0 and pcpi_rd=0 for all instructions except vsetvli.

Test Plan:
1. vsetvli 0x00817257 with rs1=8 -> pcpi_ready pulse, pcpi_wr=1, pcpi_rd=8; with rs1=20 -> pcpi_rd=8; with rs1=3 -> pcpi_rd=3.
2. vl=8, vlse.v v1 with base=400 and stride=4 over memory words 0x201, 0x605, 0xa09, ... -> exactly 8 reads at addresses 400..428, v1[i]=mem[100+i], then one ready pulse.
3. v8 filled with 0x93 and v1=v2=the words from scenario 2; vdot.vv v8,v2,v1 -> v8[0]=0x00040494 (0x93 + 0x201*0x201); each v8[i]=0x93 + v1[i]^2 mod 2^32.
4. vsse.v v8 with base=800 and stride=4 -> 8 writes with wstrb=1111 at addresses 800..828 carrying the v8 elements in order. With stride=8, the addresses are 800, 808, ..., 856.
5. Memory ready delayed 3 cycles per access -> mem_valid and mem_addr stay stable until mem_ready, no duplicate accesses, and the final data is correct.
6. Reset asserted mid-vlse -> outputs are 0 on the next cycle, vl=0; a subsequent vsetvli works normally. An unknown opcode (0x00000093) -> no wait and no ready.
